// File: rtl/serial_add_sub_if.sv
// ---------------------------------------------------------------------------
// serial_add_sub_if
//   Handshake and operand/result bundle for the bit-serial adder/subtractor.
//   Clock and reset are not part of the bundle; they stay plain ports.
//
//   start    request, sampled only while the unit is idle
//   op_sub   0: A+B, 1: A-B (sampled with start)
//   a, b     signed operands (sampled with start)
//   busy     high while the operation is in progress
//   done     one-cycle completion pulse
//   result   signed sum/difference, held until the next completion
//   c_out    carry out of the MSB (subtract: 1 = no borrow)
//   overflow signed overflow of the last operation
//
//   master: the controller issuing operations
//   slave : the serial_add_sub unit
// ---------------------------------------------------------------------------
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, c_out, overflow
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, c_out, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial signed adder/subtractor. A single full-adder cell is reused
//   for WIDTH cycles, LSB first. Subtraction is done as A + ~B + 1 by
//   inverting B at load time and seeding the carry with 1.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   serial_add_sub_if.slave (start/op_sub/a/b in;
//           busy/done/result/c_out/overflow out)
//
//   Timing: start seen in IDLE at edge E0 -> RUN for WIDTH edges -> the
//   edge processing bit WIDTH-1 loads the outputs and enters DONE, where
//   done is high for one cycle. One operation per WIDTH+2 cycles.
//
//   Build option: define SERIAL_ADD_SUB_SAT_EN to saturate the result on
//   signed overflow (c_out and overflow still report the raw condition).
//   Without it the result is the wrapped two's-complement value.
// ---------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_sub_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] sa_q,       sa_d;
  logic [WIDTH-1:0] sb_q,       sb_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             carry_q,    carry_d;
  logic             c_out_q,    c_out_d;
  logic             overflow_q, overflow_d;

  // Full-adder cell and derived values for the bit currently at sa/sb[0].
  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;
  logic             ovf_now;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] final_result;

  always_comb begin
    sum_bit    = sa_q[0] ^ sb_q[0] ^ carry_q;
    carry_next = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
    acc_next   = {sum_bit, acc_q[WIDTH-1:1]};
    last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
    // On the MSB step carry_q is the carry into bit WIDTH-1.
    ovf_now    = carry_q ^ carry_next;
`ifdef SERIAL_ADD_SUB_SAT_EN
    // On the MSB step sa_q[0] is the sign of A; on overflow both operands
    // share that sign, so it picks the saturation rail.
    if (ovf_now) begin
      final_result = sa_q[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_result = acc_next;
    end
`else
    final_result = acc_next;
`endif
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave it unassigned and infer a latch.
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    acc_d      = acc_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.op_sub ? ~bus.b : bus.b;
          carry_d = bus.op_sub;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        acc_d   = acc_next;
        carry_d = carry_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          result_d   = final_result;
          c_out_d    = carry_next;
          overflow_d = ovf_now;
          cnt_d      = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge
      // values, independent of statement order.
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Status decodes straight from the state register, so reset clears them
  // at once and done is exactly the one cycle spent in DONE.
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = overflow_q;

endmodule
